// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;

  logic             d_bit, br_next, last_bit;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current operand LSBs
  always_comb begin
    d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    res_next = WIDTH'({d_bit, res_q} >> 1);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
    diff      = diff_q;
    bout      = bout_q;
    ovf       = ovf_q;
  end

  // Datapath: load on accept, shift in RUN, publish the result on the last bit
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_next;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d = res_next;
          bout_d = br_next;
          ovf_d  = (a_msb_q != b_msb_q) & (res_next[WIDTH-1] != a_msb_q);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: arithmetic reference model checked every cycle,
// plus hand-computed literal results, latency, backpressure and mid-run reset.
module tb_serial_subtractor;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
  logic [WIDTH-1:0] a, b, diff;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 computing, 2 result presented
  int               m_phase, m_left;
  logic [WIDTH-1:0] m_diff, p_diff;
  logic             m_bout, m_ovf, p_bout, p_ovf;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_diff  = '0;
    m_bout  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_compute(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                               input logic mbin);
    int ua, ub, sa, sb, sd;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    sd = sa - sb - int'(mbin);
    p_diff = WIDTH'(ua - ub - int'(mbin));
    p_bout = (ua < ub + int'(mbin));
    p_ovf  = (sd < -(2 ** (WIDTH - 1))) || (sd > (2 ** (WIDTH - 1)) - 1);
  endtask

  task automatic compare_outputs();
    chk("in_ready",  32'(in_ready),  32'(m_phase == 0));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
    chk("diff",      32'(diff),      32'(m_diff));
    chk("bout",      32'(bout),      32'(m_bout));
    chk("ovf",       32'(ovf),       32'(m_ovf));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      case (m_phase)
        0: if (in_valid) begin
             model_compute(a, b, bin);
             m_left  = WIDTH;
             m_phase = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_phase = 2;
               m_diff  = p_diff;
               m_bout  = p_bout;
               m_ovf   = p_ovf;
             end
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
    #1;
    compare_outputs();
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic obin, input int stall, input bit early_ready, input bit noise,
                        input logic [WIDTH-1:0] ed, input logic ebo, input logic eov);
    int lat;
    chk({name, " in_ready before"}, 32'(in_ready), 32'd1);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    out_ready = early_ready;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = ~in_valid;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk({name, " latency"}, 32'(lat), 32'(WIDTH));
    chk({name, " diff"}, 32'(diff), 32'(ed));
    chk({name, " bout"}, 32'(bout), 32'(ebo));
    chk({name, " ovf"},  32'(ovf),  32'(eov));
    for (int i = 0; i < stall; i++) begin
      in_valid = ~in_valid;
      a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      step();
      chk({name, " stall in_ready"}, 32'(in_ready), 32'd0);
      chk({name, " stall diff"}, 32'(diff), 32'(ed));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk({name, " in_ready after"}, 32'(in_ready), 32'd1);
    chk({name, " retained diff"}, 32'(diff), 32'(ed));
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    step();
    step();
    #2 rst = 1'b0;

    run_op("sub5_3",   8'h05, 8'h03, 1'b0, 0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("sub3_5",   8'h03, 8'h05, 1'b0, 0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("sub80_1",  8'h80, 8'h01, 1'b0, 1, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    run_op("sub0_bin", 8'h00, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("stall",    8'h7F, 8'hFF, 1'b0, 5, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("ff_ff_b",  8'hFF, 8'hFF, 1'b1, 0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("7f_80",    8'h7F, 8'h80, 1'b0, 2, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);

    // Reset in the middle of a computation: four bits in
    a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    chk("rst diff",      32'(diff),      32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    step();
    #2 rst = 1'b0;
    run_op("post_rst", 8'h10, 8'h01, 1'b0, 0, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor that computes `a - b - bin` LSB-first through a single full-subtractor cell, taking one clock per bit. It is the sequential, inverse-direction counterpart to the team's combinational full adder in the Adders library. Operands are accepted and results returned over valid/ready handshakes, so the block can sit between a stimulus or register source and a result consumer that may apply backpressure.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be at least 1.
- `clk` input, 1 bit: single clock, rising-edge active.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: operands `a`, `b` and `bin` are valid.
- `in_ready` output, 1 bit: the block can accept operands; high only in IDLE.
- `a` input, WIDTH bits: minuend.
- `b` input, WIDTH bits: subtrahend.
- `bin` input, 1 bit: borrow in.
- `out_valid` output, 1 bit: the result is valid; high only in HOLD.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `diff` output, WIDTH bits: `(a - b - bin) mod 2^WIDTH`.
- `bout` output, 1 bit: borrow out; 1 when `a < b + bin` as unsigned values.
- `ovf` output, 1 bit: signed overflow of the subtraction.

## Operation
- FSM states: IDLE, RUN, HOLD.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `a` and `b` into shift registers, set borrow flop = `bin`, clear the bit counter, capture `a[WIDTH-1]` and `b[WIDTH-1]` for the overflow check, then go to RUN.
- **RUN:** at each edge, process bit `i` (the counter value) with `ai` = `a_sh[0]`, `bi` = `b_sh[0]`, `br` = borrow flop:
  - `d = ai ^ bi ^ br`.
  - `br_next = (~ai & bi) | (~(ai ^ bi) & br)`.
  - `d` shifts into the result register from the MSB end.
  - Both operand registers shift right.
  - The counter increments.
  - At the edge processing bit `WIDTH-1`, go to HOLD.
- **HOLD:**
  - `out_valid` = 1.
  - `diff`, `bout` and `ovf` are stable.
  - On `out_valid & out_ready`, go to IDLE.
- `ovf = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb)`, registered on entry to HOLD.
- `in_valid` is ignored outside IDLE; `out_ready` is ignored outside HOLD.
- `diff`, `bout` and `ovf` retain their last result in IDLE and change only when HOLD is entered.
- The counter is `$clog2(WIDTH)+1` bits wide, so there is no wrap for any WIDTH. WIDTH=1 performs exactly one RUN cycle.

## Timing
- Reset (asynchronous, takes effect immediately and holds while `rst` = 1):
  - State = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `diff` = 0, `bout` = 0, `ovf` = 0.
  - Borrow flop, counter and shift registers = 0.
- Latency: with the accept at edge E0, `out_valid` rises after edge E0+WIDTH.
- If `out_ready` is already high, the result is consumed at edge E0+WIDTH+1 and `in_ready` is high from then on.
- Throughput: one operation per WIDTH+2 cycles at best. Accept and result handoff never overlap.
- `in_ready` and `out_valid` are decoded from registered state only; there are no combinational paths from `in_valid` or `out_ready` to any output.
- Reset asserted mid-RUN or mid-HOLD abandons the operation with no partial output. The first edge after reset deasserts accepts normally.
- Backpressure: HOLD persists indefinitely while `out_ready` = 0, and all outputs stay stable.

## Test plan
All scenarios use WIDTH=8.
- `a`=0x05, `b`=0x03, `bin`=0, accepted at E0 -> `out_valid` after E8, `diff`=0x02, `bout`=0, `ovf`=0.
- `a`=0x03, `b`=0x05, `bin`=0 -> `diff`=0xFE, `bout`=1, `ovf`=0.
- `a`=0x80, `b`=0x01, `bin`=0 -> `diff`=0x7F, `bout`=0, `ovf`=1.
- `a`=0x00, `b`=0x00, `bin`=1 -> `diff`=0xFF, `bout`=1, `ovf`=0.
- Backpressure: `a`=0x7F, `b`=0xFF, `bin`=0, with `out_ready`=0 for 5 cycles after `out_valid` rises -> `diff`=0x80, `bout`=1, `ovf`=1 held stable throughout. During the stall `in_ready`=0, and toggling `in_valid` with new operands has no effect. After `out_ready`=1, `in_ready`=1 on the next cycle.
- Reset mid-RUN: assert `rst` at counter=4 -> all outputs 0 immediately, `in_ready`=1. After release, `a`=0x10, `b`=0x01, `bin`=0 -> `diff`=0x0F after 8 cycles.
